// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the decode operand hazard unit
package hazard_pkg;

  localparam int HZ_AW = 5;
  localparam int HZ_DW = 32;

  localparam logic [HZ_AW-1:0] REG_ZERO = '0;

  // Forwarding stage order, youngest first
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

endpackage

// File: rtl/operand_hazard_unit_if.sv
// rtl/operand_hazard_unit_if.sv - decode-side operand/bypass/scoreboard bundle
interface operand_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = HZ_AW,
  parameter int DW   = HZ_DW,
  parameter int NSRC = 3,
  parameter int NFWD = 3
);

  logic [NSRC*AW-1:0] src_addr;
  logic [NSRC-1:0]    src_used;
  logic [NSRC*DW-1:0] rf_rdata;
  logic [NFWD-1:0]    fwd_valid;
  logic [NFWD*AW-1:0] fwd_dest;
  logic [NFWD-1:0]    fwd_data_ok;
  logic [NFWD*DW-1:0] fwd_data;
  logic               issue_fire;
  logic               issue_we;
  logic [AW-1:0]      issue_dest;
  logic               wb_we;
  logic [AW-1:0]      wb_dest;
  logic               flush;
  logic [NSRC*DW-1:0] src_value;
  logic               ready_go;
  logic [NREG-1:0]    busy_vec;
  logic               sb_err;
  logic [31:0]        stall_cnt;

  modport master (
    output src_addr, src_used, rf_rdata, fwd_valid, fwd_dest, fwd_data_ok, fwd_data,
           issue_fire, issue_we, issue_dest, wb_we, wb_dest, flush,
    input  src_value, ready_go, busy_vec, sb_err, stall_cnt
  );

  modport slave (
    input  src_addr, src_used, rf_rdata, fwd_valid, fwd_dest, fwd_data_ok, fwd_data,
           issue_fire, issue_we, issue_dest, wb_we, wb_dest, flush,
    output src_value, ready_go, busy_vec, sb_err, stall_cnt
  );

endinterface

// File: rtl/operand_hazard_unit_fwd_select.sv
// rtl/operand_hazard_unit_fwd_select.sv - one source operand: youngest-match bypass mux and stall term
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW   = HZ_AW,
  parameter int DW   = HZ_DW,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]      addr,
  input  logic               used,
  input  logic [DW-1:0]      rf_rdata,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_dest,
  input  logic [NFWD-1:0]    fwd_data_ok,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               busy,
  output logic [DW-1:0]      value,
  output logic               stall
);

  logic found;

  always_comb begin
    value = rf_rdata;
    stall = 1'b0;
    found = 1'b0;
    if (addr == AW'(REG_ZERO)) begin
      value = '0;
    end else if (used) begin
      // The youngest matching stage owns the register even when its result is not ready yet
      for (int k = FWD_EX; k < NFWD; k++) begin
        if (!found && fwd_valid[k] && (fwd_dest[k*AW +: AW] == addr)) begin
          found = 1'b1;
          if (fwd_data_ok[k]) begin
            value = fwd_data[k*DW +: DW];
          end else begin
            stall = 1'b1;
          end
        end
      end
      if (!found && busy) begin
        stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_hazard_unit.sv
// rtl/operand_hazard_unit.sv - decode operand resolution, pending-write scoreboard and ready_go
module operand_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = HZ_AW,
  parameter int DW   = HZ_DW,
  parameter int NSRC = 3,
  parameter int NFWD = 3,
  parameter int CW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_hazard_unit_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0]      cnt     [NREG];
  logic [CW-1:0]      cnt_nxt [NREG];
  logic [NREG-1:0]    busy;
  logic [NREG-1:0]    inc_vec;
  logic [NREG-1:0]    dec_vec;
  logic               err_nxt;
  logic [NSRC-1:0]    stall;
  logic [NSRC*DW-1:0] src_value_flat;
  logic               ready;
  logic               sb_err_q;
  logic [31:0]        stall_cnt_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] a;
    assign a = bus.src_addr[i*AW +: AW];

    fwd_select #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_sel (
      .addr        (a),
      .used        (bus.src_used[i]),
      .rf_rdata    (bus.rf_rdata[i*DW +: DW]),
      .fwd_valid   (bus.fwd_valid),
      .fwd_dest    (bus.fwd_dest),
      .fwd_data_ok (bus.fwd_data_ok),
      .fwd_data    (bus.fwd_data),
      .busy        (busy[a]),
      .value       (src_value_flat[i*DW +: DW]),
      .stall       (stall[i])
    );
  end

  assign ready = ~|stall;

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy[r] = (cnt[r] != '0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (bus.issue_fire && bus.issue_we && (bus.issue_dest != AW'(REG_ZERO))) begin
      inc_vec[bus.issue_dest] = 1'b1;
    end
    if (bus.wb_we && (bus.wb_dest != AW'(REG_ZERO))) begin
      dec_vec[bus.wb_dest] = 1'b1;
    end
  end

  // A simultaneous issue and writeback to one register cancel; limits saturate and flag an error
  always_comb begin
    err_nxt = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt[r] == CNT_MAX) err_nxt = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt[r] == '0) err_nxt = 1'b1;
        else              cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
        for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
        if (err_nxt) sb_err_q <= 1'b1;
        if (!ready && (|bus.src_used)) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.src_value = src_value_flat;
  assign bus.ready_go  = ready;
  assign bus.busy_vec  = busy;
  assign bus.sb_err    = sb_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_hazard_unit.sv
// tb/tb_operand_hazard_unit.sv - scoreboard bench for operand_hazard_unit against a reference model
module tb_operand_hazard_unit;
  import hazard_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NSRC = 3;
  localparam int NFWD = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [NSRC*DW-1:0] val;
    logic [NSRC-1:0]    chk;
    logic               rg;
    logic [NREG-1:0]    busy;
    logic               err;
    logic [31:0]        sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  operand_hazard_unit_if #(.NREG(NREG), .AW(AW), .DW(DW), .NSRC(NSRC), .NFWD(NFWD)) bus ();

  operand_hazard_unit #(.NREG(NREG), .AW(AW), .DW(DW), .NSRC(NSRC), .NFWD(NFWD), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  int          t_addr [NSRC];
  bit          t_used [NSRC];
  logic [DW-1:0] t_rf [NSRC];
  bit          t_fv   [NFWD];
  int          t_fd   [NFWD];
  bit          t_fok  [NFWD];
  logic [DW-1:0] t_fdat [NFWD];
  bit t_fire, t_we, t_wbwe, t_flush;
  int t_idest, t_wbdest;

  int          m_cnt [NREG];
  bit          m_err;
  logic [31:0] m_sc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NSRC; i++) begin
      t_addr[i] = 0; t_used[i] = 0; t_rf[i] = $urandom;
    end
    for (int k = 0; k < NFWD; k++) begin
      t_fv[k] = 0; t_fd[k] = 0; t_fok[k] = 0; t_fdat[k] = $urandom;
    end
    t_fire = 0; t_we = 0; t_idest = 0; t_wbwe = 0; t_wbdest = 0; t_flush = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < NSRC; i++) begin
      bus.src_addr[i*AW +: AW] = AW'(t_addr[i]);
      bus.src_used[i]          = t_used[i];
      bus.rf_rdata[i*DW +: DW] = t_rf[i];
    end
    for (int k = 0; k < NFWD; k++) begin
      bus.fwd_valid[k]          = t_fv[k];
      bus.fwd_dest[k*AW +: AW]  = AW'(t_fd[k]);
      bus.fwd_data_ok[k]        = t_fok[k];
      bus.fwd_data[k*DW +: DW]  = t_fdat[k];
    end
    bus.issue_fire = t_fire;
    bus.issue_we   = t_we;
    bus.issue_dest = AW'(t_idest);
    bus.wb_we      = t_wbwe;
    bus.wb_dest    = AW'(t_wbdest);
    bus.flush      = t_flush;
  endtask

  // Operand rules: r0 reads zero, unused reads the regfile, else youngest stage match, else pending check
  task automatic resolve(input int i, output logic [DW-1:0] v, output bit st);
    bit hit;
    v = t_rf[i]; st = 0; hit = 0;
    if (t_addr[i] == 0) v = '0;
    else if (t_used[i]) begin
      for (int k = 0; k < NFWD; k++) begin
        if (!hit && t_fv[k] && t_fd[k] == t_addr[i]) begin
          hit = 1;
          if (t_fok[k]) v = t_fdat[k];
          else st = 1;
        end
      end
      if (!hit && m_cnt[t_addr[i]] > 0) st = 1;
    end
  endtask

  task automatic model_update(input bit rg);
    bit inc, dec, any_used;
    if (t_flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      return;
    end
    any_used = 0;
    for (int i = 0; i < NSRC; i++) any_used |= t_used[i];
    if (!rg && any_used) m_sc = m_sc + 1;
    inc = t_fire && t_we && t_idest != 0;
    dec = t_wbwe && t_wbdest != 0;
    if (inc && dec && t_idest == t_wbdest) return;
    if (inc) begin
      if (m_cnt[t_idest] == CMAX) m_err = 1;
      else m_cnt[t_idest]++;
    end
    if (dec) begin
      if (m_cnt[t_wbdest] == 0) m_err = 1;
      else m_cnt[t_wbdest]--;
    end
  endtask

  task automatic push_expected(output bit rg);
    exp_t e;
    logic [DW-1:0] v;
    bit st;
    e = '0; rg = 1;
    for (int i = 0; i < NSRC; i++) begin
      resolve(i, v, st);
      e.val[i*DW +: DW] = v;
      e.chk[i] = !st;
      if (st) rg = 0;
    end
    e.rg = rg;
    for (int r = 0; r < NREG; r++) e.busy[r] = (m_cnt[r] != 0);
    e.err = m_err;
    e.sc  = m_sc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    bit rg;
    @(posedge clk); #1;
    apply();
    push_expected(rg);
    model_update(rg);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready_go", 64'(bus.ready_go), 64'(e.rg));
      chk("busy_vec", 64'(bus.busy_vec), 64'(e.busy));
      chk("sb_err", 64'(bus.sb_err), 64'(e.err));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(e.sc));
      for (int i = 0; i < NSRC; i++) begin
        if (e.chk[i]) chk($sformatf("src_value[%0d]", i), 64'(bus.src_value[i*DW +: DW]), 64'(e.val[i*DW +: DW]));
      end
    end
  end

  initial begin
    bit rg;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_err = 0; m_sc = '0;
    idle(); apply();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    idle(); step();

    // back-to-back ALU dependency
    idle(); t_fv[FWD_EX] = 1; t_fd[FWD_EX] = 5; t_fok[FWD_EX] = 1; t_fdat[FWD_EX] = 32'h1234;
    t_addr[0] = 5; t_used[0] = 1; step();

    // load-use: youngest match not ready, older ready match ignored
    idle(); t_fv[FWD_EX] = 1; t_fd[FWD_EX] = 7; t_fok[FWD_EX] = 0;
    t_fv[FWD_MEM] = 1; t_fd[FWD_MEM] = 7; t_fok[FWD_MEM] = 1; t_fdat[FWD_MEM] = 32'hAA;
    t_addr[0] = 7; t_used[0] = 1; step();
    t_fv[FWD_EX] = 0; t_fdat[FWD_MEM] = 32'hBEEF; step();

    // register zero
    idle(); t_fv[FWD_EX] = 1; t_fd[FWD_EX] = 0; t_fok[FWD_EX] = 1; t_fdat[FWD_EX] = 32'hFFFF;
    t_addr[1] = 0; t_used[1] = 1; step();

    // unexposed producer on r9
    idle(); t_fire = 1; t_we = 1; t_idest = 9; step();
    idle(); t_addr[2] = 9; t_used[2] = 1; step();
    t_wbwe = 1; t_wbdest = 9; step();
    idle(); t_addr[2] = 9; t_used[2] = 1; step();
    idle(); t_fire = 1; t_we = 1; t_idest = 9; step();
    t_wbwe = 1; t_wbdest = 9; step();
    idle(); t_addr[0] = 9; t_used[0] = 1; step();

    // counter limits
    idle(); t_fire = 1; t_we = 1; t_idest = 3;
    repeat (4) step();
    idle(); t_addr[1] = 3; t_used[1] = 1; step();
    idle(); t_wbwe = 1; t_wbdest = 4; step();
    idle(); t_addr[0] = 4; t_used[0] = 1; step();

    // flush with a concurrent issue
    idle(); t_fire = 1; t_we = 1; t_idest = 10; t_flush = 1; step();
    idle(); t_addr[0] = 10; t_used[0] = 1; t_addr[1] = 3; t_used[1] = 1; step();

    // randomized traffic over a small register window
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        t_addr[i] = $urandom_range(0, 7); t_used[i] = $urandom_range(0, 3) != 0; t_rf[i] = $urandom;
      end
      for (int k = 0; k < NFWD; k++) begin
        t_fv[k] = $urandom_range(0, 1); t_fd[k] = $urandom_range(0, 7);
        t_fok[k] = $urandom_range(0, 3) != 0; t_fdat[k] = $urandom;
      end
      t_fire = $urandom_range(0, 1); t_we = $urandom_range(0, 3) != 0; t_idest = $urandom_range(0, 7);
      t_wbwe = $urandom_range(0, 2) == 0; t_wbdest = $urandom_range(0, 7);
      t_flush = $urandom_range(0, 31) == 0;
      step();
    end

    // asynchronous reset in the middle of a cycle
    idle(); t_addr[0] = 3; t_used[0] = 1; step();
    @(posedge clk); #1;
    idle(); apply();
    #1 reset = 1'b1;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_err = 0; m_sc = '0;
    #1 chk("async_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("async_sb_err", 64'(bus.sb_err), 64'd0);
    push_expected(rg);
    @(negedge clk); #1 reset = 1'b0;
    model_update(rg);
    idle(); t_fire = 1; t_we = 1; t_idest = 6; step();
    idle(); t_addr[0] = 6; t_used[0] = 1; step();

    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
